// File: rtl/decode_regfile.sv
// RV32 issue stage: decodes one instruction per cycle, reads operands from a 32x32
// register file, issues to the ALU and retires results in order via a pending-rd queue.
module decode_regfile #(
  parameter int PEND_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        r_i_s_instr_types,
  output logic [2:0]  funct3,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic        out_valid,
  input  logic [31:0] wb_data,
  input  logic        wb_valid,
  output logic        illegal_instr,
  output logic        wb_underflow,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  localparam int PW = $clog2(PEND_DEPTH);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  function automatic logic signed [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  logic [31:0]           rf [32];
  logic [4:0]            pend_rd [PEND_DEPTH];
  logic [PEND_DEPTH-1:0] pend_vld;
  logic [PW-1:0]         head, tail;

  logic [4:0]         rs1, rs2, rd_p0;
  logic [31:0]        rs1_val, rs2_val;
  logic signed [31:0] a_p0, b_p0;
  logic               legal_p0, ris_p0, use_rs1, use_rs2;
  logic               full, empty, hazard, fire, vld_p0, pop;

  assign rs1     = instr[19:15];
  assign rs2     = instr[24:20];
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : rf[rs2];

  // Stage p0: combinational decode and operand fetch
  always_comb begin
    legal_p0 = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    ris_p0   = 1'b0;
    rd_p0    = 5'd0;
    a_p0     = '0;
    b_p0     = '0;
    case (instr[6:0])
      OP_R: begin
        legal_p0 = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        ris_p0   = 1'b1;
        rd_p0    = instr[11:7];
        a_p0     = rs1_val;
        b_p0     = rs2_val;
      end
      OP_I: begin
        legal_p0 = 1'b1;
        use_rs1  = 1'b1;
        ris_p0   = 1'b1;
        rd_p0    = instr[11:7];
        a_p0     = rs1_val;
        b_p0     = sext12(instr[31:20]);
      end
      OP_S: begin
        legal_p0 = 1'b1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        a_p0     = rs1_val;
        b_p0     = sext12({instr[31:25], instr[11:7]});
      end
      OP_LUI: begin
        legal_p0 = 1'b1;
        rd_p0    = instr[11:7];
        b_p0     = {instr[31:12], 12'd0};
      end
      default: legal_p0 = 1'b0;
    endcase
  end

  // A pending x0 never blocks; a writeback in this cycle still counts as pending.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < PEND_DEPTH; i++) begin
      if (pend_vld[i] && pend_rd[i] != 5'd0 &&
          ((use_rs1 && pend_rd[i] == rs1) || (use_rs2 && pend_rd[i] == rs2)))
        hazard = 1'b1;
    end
  end

  assign full        = &pend_vld;
  assign empty       = ~|pend_vld;
  assign instr_ready = !full && !hazard;
  assign fire        = instr_valid && instr_ready;
  assign vld_p0      = fire && legal_p0;
  assign pop         = wb_valid && !empty;
  assign dbg_data    = (dbg_addr == 5'd0) ? 32'd0 : rf[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      pend_vld <= '0;
    end else begin
      if (pop) begin
        pend_vld[head] <= 1'b0;
        head           <= head + 1'b1;
      end
      if (vld_p0) begin
        pend_vld[tail] <= 1'b1;
        tail           <= tail + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0) pend_rd[tail] <= rd_p0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (pop && pend_rd[head] != 5'd0) begin
      rf[pend_rd[head]] <= wb_data;
    end
  end

  // Stage p1: registered ALU-facing outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid         <= 1'b0;
      illegal_instr     <= 1'b0;
      wb_underflow      <= 1'b0;
      funct3            <= '0;
      r_i_s_instr_types <= 1'b0;
      a_out             <= '0;
      b_out             <= '0;
    end else begin
      out_valid     <= vld_p0;
      illegal_instr <= fire && !legal_p0;
      if (wb_valid && empty) wb_underflow <= 1'b1;
      if (fire) funct3 <= instr[14:12];
      if (vld_p0) begin
        r_i_s_instr_types <= ris_p0;
        a_out             <= a_p0;
        b_out             <= b_p0;
      end
    end
  end

endmodule

// File: tb/tb_decode_regfile.sv
// Bench for decode_regfile: decode vector table, directed hazard/queue/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_decode_regfile;

  localparam int PEND_DEPTH = 4;

  logic        clk, rst;
  logic [31:0] instr;
  logic        instr_valid, instr_ready;
  logic        r_i_s_instr_types;
  logic [2:0]  funct3;
  logic [31:0] a_out, b_out;
  logic        out_valid;
  logic [31:0] wb_data;
  logic        wb_valid;
  logic        illegal_instr, wb_underflow;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  decode_regfile #(.PEND_DEPTH(PEND_DEPTH)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .r_i_s_instr_types(r_i_s_instr_types),
    .funct3(funct3), .a_out(a_out), .b_out(b_out), .out_valid(out_valid),
    .wb_data(wb_data), .wb_valid(wb_valid), .illegal_instr(illegal_instr),
    .wb_underflow(wb_underflow), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] ins;
    logic        ev;
    logic        ill;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f3;
    logic        ris;
  } vec_t;
  vec_t tbl[8];

  // reference model state
  logic [31:0] mregs [32];
  int          pq[$];
  bit          m_under;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    instr = ins;
    instr_valid = 1'b1;
    #1;
    chk("issue_ready", {31'd0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
  endtask

  task automatic wb(input logic [31:0] d);
    wb_valid = 1'b1;
    wb_data = d;
    tick();
    wb_valid = 1'b0;
  endtask

  task automatic model_dec(input logic [31:0] in, output bit legal, output bit u1,
                           output bit u2, output int dst, output logic [31:0] a,
                           output logic [31:0] b, output bit ris);
    legal = 1; u1 = 0; u2 = 0; dst = 0; a = 0; b = 0; ris = 0;
    case (in[6:0])
      7'b0110011: begin u1 = 1; u2 = 1; ris = 1; dst = int'(in[11:7]);
                        a = mregs[in[19:15]]; b = mregs[in[24:20]]; end
      7'b0010011: begin u1 = 1; ris = 1; dst = int'(in[11:7]);
                        a = mregs[in[19:15]]; b = 32'($signed(in[31:20])); end
      7'b0100011: begin u1 = 1; u2 = 1; a = mregs[in[19:15]];
                        b = 32'($signed({in[31:25], in[11:7]})); end
      7'b0110111: begin dst = int'(in[11:7]); b = {in[31:12], 12'd0}; end
      default: legal = 0;
    endcase
  endtask

  bit          legal, u1, u2, eris, haz, eready, fire;
  int          dst, h;
  logic [31:0] ea, eb, r;
  logic [6:0]  op;

  initial begin
    tbl[0] = '{32'h00500093, 1'b1, 1'b0, 32'h0, 32'h00000005, 3'd0, 1'b1};
    tbl[1] = '{32'hFFF00093, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 3'd0, 1'b1};
    tbl[2] = '{32'h000002B3, 1'b1, 1'b0, 32'h0, 32'h00000000, 3'd0, 1'b1};
    tbl[3] = '{32'hFE002E23, 1'b1, 1'b0, 32'h0, 32'hFFFFFFFC, 3'd2, 1'b0};
    tbl[4] = '{32'h123451B7, 1'b1, 1'b0, 32'h0, 32'h12345000, 3'd5, 1'b0};
    tbl[5] = '{32'h0000007F, 1'b0, 1'b1, 32'h0, 32'h0,        3'd0, 1'b0};
    tbl[6] = '{32'h00000003, 1'b0, 1'b1, 32'h0, 32'h0,        3'd0, 1'b0};
    tbl[7] = '{32'h80000037, 1'b1, 1'b0, 32'h0, 32'h80000000, 3'd0, 1'b0};

    rst = 1'b1; instr = '0; instr_valid = 1'b0; wb_data = '0; wb_valid = 1'b0; dbg_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_a_out", a_out, 32'd0);
    chk("rst_b_out", b_out, 32'd0);
    chk("rst_underflow", {31'd0, wb_underflow}, 32'd0);
    chk("rst_illegal", {31'd0, illegal_instr}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);

    // addi x1,x0,5 then dependent add x2,x1,x1
    issue(32'h00500093);
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_a", a_out, 32'd0);
    chk("addi_b", b_out, 32'd5);
    chk("addi_f3", {29'd0, funct3}, 32'd0);
    chk("addi_ris", {31'd0, r_i_s_instr_types}, 32'd1);
    instr = 32'h00108133; instr_valid = 1'b1;
    #1 chk("raw_stall0", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("raw_novalid", {31'd0, out_valid}, 32'd0);
    chk("raw_stall1", {31'd0, instr_ready}, 32'd0);
    wb_valid = 1'b1; wb_data = 32'd5;
    #1 chk("raw_stall_wb", {31'd0, instr_ready}, 32'd0);
    tick();
    wb_valid = 1'b0; dbg_addr = 5'd1;
    #1 chk("raw_release", {31'd0, instr_ready}, 32'd1);
    chk("dbg_x1", dbg_data, 32'd5);
    tick();
    instr_valid = 1'b0;
    chk("raw_valid", {31'd0, out_valid}, 32'd1);
    chk("raw_a", a_out, 32'd5);
    chk("raw_b", b_out, 32'd5);
    wb(32'd10);
    dbg_addr = 5'd2;
    #1 chk("dbg_x2", dbg_data, 32'd10);

    // x0 destination pending does not stall readers of x0
    issue(32'h00700013);
    chk("x0_b", b_out, 32'd7);
    issue(32'h00000433);
    wb(32'd7);
    wb(32'd0);
    dbg_addr = 5'd0;
    #1 chk("dbg_x0", dbg_data, 32'd0);

    issue(32'h123451B7);
    chk("lui_a", a_out, 32'd0);
    chk("lui_b", b_out, 32'h12345000);
    chk("lui_ris", {31'd0, r_i_s_instr_types}, 32'd0);
    chk("lui_f3", {29'd0, funct3}, 32'd5);
    wb(32'h12345000);
    dbg_addr = 5'd3;
    #1 chk("dbg_x3", dbg_data, 32'h12345000);

    // queue full
    for (int i = 0; i < 4; i++) issue(((32'h10 + i) << 20) | ((4 + i) << 7) | 32'h13);
    instr = 32'h00100493; instr_valid = 1'b1;
    #1 chk("full_stall0", {31'd0, instr_ready}, 32'd0);
    tick();
    chk("full_stall1", {31'd0, instr_ready}, 32'd0);
    wb_valid = 1'b1; wb_data = 32'h44;
    #1 chk("full_stall_wb", {31'd0, instr_ready}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1 chk("full_release", {31'd0, instr_ready}, 32'd1);
    tick();
    instr_valid = 1'b0;
    chk("full_fifth_valid", {31'd0, out_valid}, 32'd1);
    chk("full_fifth_b", b_out, 32'd1);
    dbg_addr = 5'd4;
    #1 chk("dbg_x4", dbg_data, 32'h44);
    wb(32'h55); wb(32'h66); wb(32'h77); wb(32'h99);
    dbg_addr = 5'd7;
    #1 chk("dbg_x7", dbg_data, 32'h77);
    dbg_addr = 5'd9;
    #1 chk("dbg_x9", dbg_data, 32'h99);

    // illegal opcode and writeback underflow
    issue(32'h0000007F);
    chk("ill_pulse", {31'd0, illegal_instr}, 32'd1);
    chk("ill_novalid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("ill_drop", {31'd0, illegal_instr}, 32'd0);
    wb(32'hDEAD);
    chk("underflow_set", {31'd0, wb_underflow}, 32'd1);
    dbg_addr = 5'd1;
    #1 chk("underflow_x1", dbg_data, 32'd5);
    tick();
    chk("underflow_sticky", {31'd0, wb_underflow}, 32'd1);

    // reset between issue and writeback
    issue(32'h00300513);
    chk("mid_valid", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_b", b_out, 32'd0);
    chk("mid_rst_underflow", {31'd0, wb_underflow}, 32'd0);
    chk("mid_rst_x1", dbg_data, 32'd0);
    #1 rst = 1'b0;
    issue(32'h00A505B3);
    wb(32'd0);

    // decode vector table
    for (int i = 0; i < 8; i++) begin
      issue(tbl[i].ins);
      chk("tbl_valid", {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk("tbl_illegal", {31'd0, illegal_instr}, {31'd0, tbl[i].ill});
      chk("tbl_f3", {29'd0, funct3}, {29'd0, tbl[i].f3});
      if (tbl[i].ev) begin
        chk("tbl_a", a_out, tbl[i].a);
        chk("tbl_b", b_out, tbl[i].b);
        chk("tbl_ris", {31'd0, r_i_s_instr_types}, {31'd0, tbl[i].ris});
        wb(32'd0);
      end
    end

    // randomized traffic against the model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    pq.delete();
    m_under = 0;
    for (int c = 0; c < 500; c++) begin
      r = $urandom;
      case ($urandom_range(0, 4))
        0: op = 7'b0110011;
        1: op = 7'b0010011;
        2: op = 7'b0100011;
        3: op = 7'b0110111;
        default: op = r[0] ? 7'h7F : 7'h03;
      endcase
      r[6:0] = op;
      r[11:7] = 5'($urandom_range(0, 7));
      r[19:15] = 5'($urandom_range(0, 7));
      r[24:20] = 5'($urandom_range(0, 7));
      instr = r;
      instr_valid = ($urandom_range(0, 3) != 0);
      wb_valid = (pq.size() > 0) && ($urandom_range(0, 1) == 1);
      wb_data = $urandom;
      dbg_addr = 5'($urandom_range(0, 15));
      #1;
      model_dec(instr, legal, u1, u2, dst, ea, eb, eris);
      haz = 0;
      foreach (pq[k])
        if (pq[k] != 0 && ((u1 && pq[k] == int'(instr[19:15])) ||
                           (u2 && pq[k] == int'(instr[24:20])))) haz = 1;
      eready = (pq.size() < PEND_DEPTH) && !haz;
      chk("rnd_ready", {31'd0, instr_ready}, {31'd0, eready});
      chk("rnd_dbg", dbg_data, mregs[dbg_addr]);
      fire = instr_valid && eready;
      tick();
      if (wb_valid) begin
        if (pq.size() > 0) begin
          h = pq.pop_front();
          if (h != 0) mregs[h] = wb_data;
        end else m_under = 1;
      end
      if (fire && legal) pq.push_back(dst);
      chk("rnd_valid", {31'd0, out_valid}, {31'd0, fire && legal});
      chk("rnd_illegal", {31'd0, illegal_instr}, {31'd0, fire && !legal});
      chk("rnd_underflow", {31'd0, wb_underflow}, {31'd0, m_under});
      if (fire && legal) begin
        chk("rnd_a", a_out, ea);
        chk("rnd_b", b_out, eb);
        chk("rnd_f3", {29'd0, funct3}, {29'd0, instr[14:12]});
        chk("rnd_ris", {31'd0, r_i_s_instr_types}, {31'd0, eris});
      end
    end
    instr_valid = 1'b0;
    wb_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
